// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing defaults plus phase and controller state types
package vga_timing_pkg;
  localparam int DEF_DIVISOR   = 2;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_CW        = 10;
  typedef enum logic [1:0] {PH_VISIBLE, PH_FRONT, PH_SYNC, PH_BACK} phase_t;
  typedef enum logic {IDLE, ACTIVE} ctrl_state_t;
endpackage

// File: rtl/vga_axis_seq.sv
// vga_axis_seq: one timing axis, a wrapping counter with visible/front/sync/back phase decode
module vga_axis_seq
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK,
  parameter int CW      = DEF_CW
) (
  input  logic          clock_in,
  input  logic          rst_n,
  input  logic          advance,
  input  logic          clear,
  output logic [CW-1:0] count,
  output phase_t        phase,
  output logic          wrap
);
  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
  logic [31:0] c;
  assign c = 32'(count);
  assign wrap = advance && c == TOTAL - 1;
  assign phase = c < VISIBLE ? PH_VISIBLE :
                 c < VISIBLE + FRONT ? PH_FRONT :
                 c < VISIBLE + FRONT + SYNC ? PH_SYNC : PH_BACK;
  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (clear || wrap) count <= '0;
    else if (advance) count <= count + CW'(1);
  end
endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: pixel-tick divider and frame sequencer producing VGA sync, coordinates and
// start pulses, starting and stopping only on whole-frame boundaries
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int   DIVISOR     = DEF_DIVISOR,
  parameter int   H_VISIBLE   = DEF_H_VISIBLE,
  parameter int   H_FRONT     = DEF_H_FRONT,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BACK      = DEF_H_BACK,
  parameter int   V_VISIBLE   = DEF_V_VISIBLE,
  parameter int   V_FRONT     = DEF_V_FRONT,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BACK      = DEF_V_BACK,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   CW          = DEF_CW
) (
  input  logic          clock_in,
  input  logic          rst_n,
  input  logic          run,
  output logic          running,
  output logic          pixel_tick,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_start,
  output logic          frame_start
);
  localparam int DW = DIVISOR > 1 ? $clog2(DIVISOR) : 1;
  ctrl_state_t state_q, state_d;
  logic stop_q, stop_d, ls_d, fs_d, h_wrap, v_wrap;
  logic [DW-1:0] div_cnt;
  phase_t h_phase, v_phase;
  assign running = state_q == ACTIVE;
  assign pixel_tick = running && 32'(div_cnt) == DIVISOR - 1;
  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) div_cnt <= '0;
    else div_cnt <= (running && !pixel_tick) ? div_cnt + DW'(1) : '0;
  end
  vga_axis_seq #(.VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .CW(CW)) u_h (
    .clock_in(clock_in), .rst_n(rst_n), .advance(pixel_tick), .clear(!running),
    .count(x), .phase(h_phase), .wrap(h_wrap)
  );
  vga_axis_seq #(.VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .CW(CW)) u_v (
    .clock_in(clock_in), .rst_n(rst_n), .advance(h_wrap), .clear(!running),
    .count(y), .phase(v_phase), .wrap(v_wrap)
  );
  // stop_q reflects run as sampled on the previous edge, so run dropping on the wrap edge itself costs one more frame
  always_comb begin
    state_d = state_q == IDLE ? (run ? ACTIVE : IDLE) : (v_wrap && stop_q ? IDLE : ACTIVE);
    stop_d = state_q == ACTIVE && state_d == ACTIVE && !run;
    ls_d = state_d == ACTIVE && (state_q == IDLE || h_wrap);
    fs_d = state_d == ACTIVE && (state_q == IDLE || v_wrap);
  end
  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stop_q <= 1'b0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state_q <= state_d;
      stop_q <= stop_d;
      line_start <= ls_d;
      frame_start <= fs_d;
    end
  end
  assign hsync = running && h_phase == PH_SYNC ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vsync = running && v_phase == PH_SYNC ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign video_on = running && h_phase == PH_VISIBLE && v_phase == PH_VISIBLE;
endmodule
